// File: rtl/char_row_serializer.sv
// char_row_serializer: issues the glyph-row ROM address ahead of the glyph and shifts the returned row out MSB-first.
module char_row_serializer #(
    parameter int CHAR_W = 8,
    parameter int CHAR_H = 16,
    parameter int LEAD   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pixel_en,
    input  logic [9:0]        h_val,
    input  logic [9:0]        v_val,
    input  logic [9:0]        x_pos,
    input  logic [9:0]        y_pos,
    input  logic [6:0]        ascii_addr,
    output logic [10:0]       rom_addr,
    input  logic [CHAR_W-1:0] rom_data,
    output logic              pixel_on,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, WAIT_ROM, PRIME, SHIFT} state_t;
    localparam int CW = $clog2(CHAR_W + 1);
    state_t            state, state_nx;
    logic [CHAR_W-1:0] shreg, shreg_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [10:0]       rom_addr_nx;
    logic              pixel_on_nx;
    logic [10:0]       v_ext, y_ext, h_ext, x_ext;
    logic              in_box, trigger;
    logic [3:0]        row;

    // Beam-position decode, widened to 11 bits so the box and lead compares never wrap.
    always_comb begin
        v_ext   = {1'b0, v_val};
        y_ext   = {1'b0, y_pos};
        h_ext   = {1'b0, h_val};
        x_ext   = {1'b0, x_pos};
        in_box  = (v_ext >= y_ext) && (v_ext < y_ext + 11'(CHAR_H));
        row     = 4'(v_ext - y_ext);
        trigger = pixel_en && in_box && (h_ext + 11'(LEAD) == x_ext);
    end

    // Next-state and datapath; nothing moves without a pixel tick, so every register holds otherwise.
    always_comb begin
        state_nx    = state;
        rom_addr_nx = rom_addr;
        pixel_on_nx = pixel_on;
        shreg_nx    = shreg;
        cnt_nx      = cnt;
        if (pixel_en) begin
            case (state)
                IDLE: if (trigger) begin
                    rom_addr_nx = {ascii_addr, 4'hF - row};
                    state_nx    = WAIT_ROM;
                end
                WAIT_ROM: state_nx = PRIME;
                PRIME: begin
                    shreg_nx    = rom_data << 1;
                    pixel_on_nx = rom_data[CHAR_W-1];
                    cnt_nx      = CW'(1);
                    state_nx    = SHIFT;
                end
                SHIFT: if (cnt < CW'(CHAR_W)) begin
                    pixel_on_nx = shreg[CHAR_W-1];
                    shreg_nx    = shreg << 1;
                    cnt_nx      = cnt + CW'(1);
                end else begin
                    pixel_on_nx = 1'b0;
                    state_nx    = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            rom_addr <= '0;
            pixel_on <= 1'b0;
            shreg    <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_nx;
            rom_addr <= rom_addr_nx;
            pixel_on <= pixel_on_nx;
            shreg    <= shreg_nx;
            cnt      <= cnt_nx;
        end
    end

    assign busy = (state != IDLE);
endmodule
